// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit: opcodes, FSM states
// and HI/LO write-enable codes.
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'd0,
        OP_MULTU = 2'd1,
        OP_DIV   = 2'd2,
        OP_DIVU  = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    localparam logic [1:0] WB_NONE = 2'b00;
    localparam logic [1:0] WB_LO   = 2'b01;
    localparam logic [1:0] WB_HI   = 2'b10;
    localparam logic [1:0] WB_BOTH = 2'b11;

    localparam int ITERS = 32;

    function automatic logic [31:0] mag(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared datapath: shift-add multiply (multiplier in lo,
// consumed LSB first) or restoring divide (dividend in lo, quotient shifted in).
module muldiv_step
    import muldiv_pkg::*;
(
    input  logic        is_div,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    input  logic [31:0] b,
    output logic [31:0] hi_next,
    output logic [31:0] lo_next
);

    logic [32:0] sum;
    logic [32:0] shifted;
    logic        q_bit;

    always_comb begin
        sum     = {1'b0, hi} + {1'b0, b};
        shifted = {hi, lo[31]};
        q_bit   = 1'b0;
        hi_next = hi;
        lo_next = lo;
        if (is_div) begin
            // Remainder stays below the divisor, so the difference always fits in 32 bits.
            q_bit   = (shifted >= {1'b0, b});
            hi_next = q_bit ? (shifted[31:0] - b) : shifted[31:0];
            lo_next = {lo[30:0], q_bit};
        end else if (lo[0]) begin
            hi_next = sum[32:1];
            lo_next = {sum[0], lo[31:1]};
        end else begin
            hi_next = {1'b0, hi[31:1]};
            lo_next = {hi[0], lo[31:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU unit: 32 RUN cycles on magnitudes,
// one FIX cycle for sign correction, one DONE cycle that writes HI/LO.
module muldiv_unit
    import muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [1:0]  write_hilo,
    output logic [63:0] hilo
);

    state_e      state, state_nxt;
    logic [4:0]  cnt;
    logic        is_div, neg_res, neg_rem, div_zero;
    logic [31:0] hi_q, lo_q, b_q, hi_step, lo_step;
    logic        accept, is_signed, sa, sb;
    logic [63:0] prod, result;
    logic [31:0] quo, rem;

    assign is_signed = (op == OP_MULT) || (op == OP_DIV);
    assign sa        = is_signed & src_a[31];
    assign sb        = is_signed & src_b[31];
    assign accept    = start && !flush && (state == S_IDLE || state == S_DONE);

    muldiv_step u_step (
        .is_div  (is_div),
        .hi      (hi_q),
        .lo      (lo_q),
        .b       (b_q),
        .hi_next (hi_step),
        .lo_next (lo_step)
    );

    always_comb begin
        state_nxt  = state;
        busy       = 1'b0;
        done       = 1'b0;
        write_hilo = WB_NONE;
        case (state)
            S_IDLE: if (accept) state_nxt = S_RUN;
            S_RUN: begin
                busy = 1'b1;
                if (cnt == 5'(ITERS - 1)) state_nxt = S_FIX;
            end
            S_FIX: begin
                busy      = 1'b1;
                state_nxt = S_DONE;
            end
            S_DONE: begin
                done       = 1'b1;
                write_hilo = WB_BOTH;
                state_nxt  = accept ? S_RUN : S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        if (flush) state_nxt = S_IDLE;
    end

    // Sign fix-up; divide-by-zero bypasses quotient negation and reports all ones.
    always_comb begin
        prod = {hi_q, lo_q};
        quo  = neg_res ? (~lo_q + 32'd1) : lo_q;
        rem  = neg_rem ? (~hi_q + 32'd1) : hi_q;
        if (is_div) result = {rem, div_zero ? 32'hFFFF_FFFF : quo};
        else        result = neg_res ? (~prod + 64'd1) : prod;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            b_q      <= '0;
            is_div   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            hilo     <= '0;
        end else begin
            if (accept) begin
                cnt      <= '0;
                hi_q     <= '0;
                lo_q     <= mag(src_a, sa);
                b_q      <= mag(src_b, sb);
                is_div   <= op[1];
                neg_res  <= sa ^ sb;
                neg_rem  <= sa;
                div_zero <= op[1] && (src_b == 32'd0);
            end else if (state == S_RUN) begin
                hi_q <= hi_step;
                lo_q <= lo_step;
                cnt  <= cnt + 5'd1;
            end
            if (state == S_FIX && !flush) hilo <= result;
        end
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have no parameters; the datapath width SHALL be fixed at 32 bits.
REQ-002 clk  in  1  single clock, all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 start  in  1  request a new operation; sampled only when accepted (REQ-011).
REQ-005 op  in  2  operation: 0=MULT, 1=MULTU, 2=DIV, 3=DIVU.
REQ-006 src_a  in  32  multiplicand / dividend (rs).
REQ-007 src_b  in  32  multiplier / divisor (rt).
REQ-008 flush  in  1  cancel any in-flight operation.
REQ-009 busy  out  1  pipeline stall request while an operation is in progress.
REQ-010 done, write_hilo[1:0], hilo[63:0]  out  completion pulse, HI/LO write enable (2'b11 on completion, else 2'b00), result {HI,LO}.

Function
REQ-011 start SHALL be accepted only in IDLE or DONE state with flush low; start at any other time SHALL be ignored.
REQ-012 States SHALL be IDLE, RUN, FIX, DONE; acceptance -> RUN; RUN -> FIX after 32 iterations; FIX -> DONE; DONE -> RUN if start accepted, else IDLE.
REQ-013 Timing, start high in cycle 0: RUN in cycles 1-32, FIX in cycle 33, DONE in cycle 34; busy SHALL be 1 exactly in RUN and FIX.
REQ-014 done SHALL be 1 and write_hilo SHALL be 2'b11 only in DONE, for exactly one cycle per completed operation.
REQ-015 At acceptance, operands, op and result signs SHALL be latched; signed ops SHALL operate on 32-bit magnitudes.
REQ-016 Multiply SHALL be iterative shift-add, one multiplier bit per RUN cycle; product = {HI,LO}; signed product negated in FIX when signs differ.
REQ-017 Divide SHALL be iterative restoring, one quotient bit per RUN cycle; LO = quotient, HI = remainder.
REQ-018 Signed divide: quotient negative iff operand signs differ; remainder sign SHALL follow dividend.
REQ-019 0x80000000 / 0xFFFFFFFF (DIV) SHALL yield LO=0x80000000, HI=0x00000000.
REQ-020 Divide by zero (DIV or DIVU) SHALL still take the full latency and yield HI=src_a, LO=0xFFFFFFFF.
REQ-021 hilo SHALL be registered, updated only on entering DONE, and held unchanged otherwise.
REQ-022 flush high in any state SHALL force IDLE at the next edge, with no done or write_hilo for the cancelled operation and hilo unchanged; flush SHALL win over a simultaneous start.
REQ-023 A start accepted in the DONE cycle SHALL begin RUN in the next cycle (back-to-back; result of previous op visible in that DONE cycle).

Reset
REQ-024 rst_n low SHALL immediately force IDLE, busy=0, done=0, write_hilo=2'b00, hilo=0, iteration counter=0, independent of clk.
REQ-025 Reset asserted mid-operation SHALL discard the operation; no completion SHALL follow reset release without a new start.

Structure
REQ-026 Op encodings (MULT/MULTU/DIV/DIVU), the state enum, and the WB write_hilo encodings (2'b11 both, 2'b10 HI, 2'b01 LO) SHALL live in shared package muldiv_pkg.
REQ-027 One combinational sub-module, muldiv_step, SHALL compute one multiply/divide iteration (next partial/remainder, next quotient bit); the FSM, counter and sign fix-up SHALL stay in muldiv_unit.

Verification
REQ-028 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> busy cycles 1-33, done in cycle 34, hilo=0xFFFFFFFE_00000001, write_hilo=2'b11 for one cycle.
REQ-029 MULT 0xFFFFFFFD(-3) x 0x00000005 -> hilo=0xFFFFFFFF_FFFFFFF1; DIV 0xFFFFFFF9(-7) / 2 -> HI=0xFFFFFFFF, LO=0xFFFFFFFD.
REQ-030 DIVU 0x00000007 / 0 -> hilo=0x00000007_FFFFFFFF after 34 cycles; DIV 0x80000000 / 0xFFFFFFFF -> hilo=0x00000000_80000000.
REQ-031 DIVU 100/7 started, flush in cycle 10 -> busy=0 from cycle 11, no done, hilo unchanged; new start cycle 11 completes in cycle 45.
REQ-032 MULTU 3x4 with second start (DIVU 9/2) in its DONE cycle -> hilo=0x0..0C at cycle 34, then HI=1, LO=4 at cycle 68; start while busy ignored.
REQ-033 rst_n pulsed low mid-RUN (cycle 20, asynchronous to clk) -> all outputs 0 immediately, no done after release.
